demux2_reg: RTL



---
 rtl/sisc_demux_pkg.sv | 14 +
 rtl/demux_slot.sv | 57 +++++
 rtl/demux2_reg.sv | 84 ++++++++
 3 files changed

// File: rtl/sisc_demux_pkg.sv
// rtl/sisc_demux_pkg.sv - shared select codes, data width and slot-state encoding for the SISC demux
package sisc_demux_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DATA_W = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register with EMPTY/FULL state, optional transfer counter (DEMUX2_CNT_EN)
module demux_slot
  import sisc_demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
`ifdef DEMUX2_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             can_load,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt
`endif
);

  slot_state_e state;
  logic        drain;

  assign valid    = (state == FULL);
  assign drain    = valid && ready;
  // A full slot can take a new word only if the current one leaves this same cycle.
  assign can_load = !valid || ready;

  // Slot state and data: a load always wins (covers pass-through), a bare drain empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      data  <= '0;
    end else if (load) begin
      state <= FULL;
      data  <= load_data;
    end else if (drain) begin
      state <= EMPTY;
    end
  end

`ifdef DEMUX2_CNT_EN
  // Completed output transfers, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (drain) begin
      cnt <= cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/demux2_reg.sv
// rtl/demux2_reg.sv - registered 1-to-2 demultiplexer with valid/ready slots; DEMUX2_CNT_EN adds transfer counters
module demux2_reg
  import sisc_demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
`ifdef DEMUX2_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
`endif
);

  logic can_load_a;
  logic can_load_b;
  logic load_a;
  logic load_b;

  // Readiness follows only the selected slot; in_valid never feeds in_ready.
  always_comb begin
    in_ready = (in_sel == SEL_A) ? can_load_a : can_load_b;
    load_a   = in_valid && in_ready && (in_sel == SEL_A);
    load_b   = in_valid && in_ready && (in_sel == SEL_B);
  end

  demux_slot #(
    .WIDTH(WIDTH)
`ifdef DEMUX2_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_slot_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load_a),
    .load_data(in_data),
    .can_load (can_load_a),
    .data     (out_a_data),
    .valid    (out_a_valid),
    .ready    (out_a_ready)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt      (cnt_a)
`endif
  );

  demux_slot #(
    .WIDTH(WIDTH)
`ifdef DEMUX2_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_slot_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load_b),
    .load_data(in_data),
    .can_load (can_load_b),
    .data     (out_b_data),
    .valid    (out_b_valid),
    .ready    (out_b_ready)
`ifdef DEMUX2_CNT_EN
    ,
    .cnt      (cnt_b)
`endif
  );

endmodule
